// File: rtl/handshake_peer_if.sv
// rtl/handshake_peer_if.sv - board-side handshake bus between the button peer and the picoMips core
interface handshake_peer_if #(
  parameter int WIDTH = 8
);
  logic             Button;
  logic [WIDTH-1:0] SwitchesIn;
  logic [WIDTH-1:0] ResultIn;
  logic             Handshake;
  logic [WIDTH-1:0] SW;
  logic [WIDTH-1:0] LedOut;
  logic [7:0]       PressCount;
  logic             Busy;

  modport master (
    input  Button, SwitchesIn, ResultIn,
    output Handshake, SW, LedOut, PressCount, Busy
  );

  modport slave (
    output Button, SwitchesIn, ResultIn,
    input  Handshake, SW, LedOut, PressCount, Busy
  );
endinterface

// File: rtl/handshake_peer.sv
// rtl/handshake_peer.sv - debounced push-button peer driving the picoMips Handshake/SW protocol
module handshake_peer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MIN_HOLD        = 4,
  parameter int GAP_CYCLES      = 4
) (
  input  logic              Clock,
  input  logic              nReset,
  handshake_peer_if.master  bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MIN_HOLD - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  state_t           state;
  logic             sync1, sync2;
  logic             db_level, db_prev;
  logic [DW-1:0]    db_cnt;
  logic [HW-1:0]    hold_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [WIDTH-1:0] sw_q, led_q;
  logic [7:0]       count_q;
  logic             hs_q, busy_q;
  logic             press;

  // Rising edge of the debounced level; db_prev keeps a held button from re-triggering.
  assign press = db_level & ~db_prev;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1   <= bus.Button;
      sync2   <= sync1;
      db_prev <= db_level;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt >= DB_LAST) begin
        db_level <= sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      sw_q     <= '0;
      led_q    <= '0;
      count_q  <= '0;
      hs_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (press) begin
            sw_q     <= bus.SwitchesIn;
            hold_cnt <= '0;
            hs_q     <= 1'b1;
            busy_q   <= 1'b1;
            state    <= HIGH;
          end
        end
        HIGH: begin
          if (hold_cnt >= HOLD_LAST && !db_level) begin
            led_q   <= bus.ResultIn;
            count_q <= count_q + 8'd1;
            gap_cnt <= '0;
            hs_q    <= 1'b0;
            state   <= GAP;
          end else if (hold_cnt < HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        GAP: begin
          // Presses seen here are dropped, not queued.
          if (gap_cnt >= GAP_LAST) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          hs_q   <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.Handshake  = hs_q;
  assign bus.SW         = sw_q;
  assign bus.LedOut     = led_q;
  assign bus.PressCount = count_q;
  assign bus.Busy       = busy_q;

endmodule

// File: tb/tb_handshake_peer.sv
// tb/tb_handshake_peer.sv - directed self-checking bench for handshake_peer
module tb_handshake_peer;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   rises_a  = 0;
  int   rises_b  = 0;
  logic hs_a_q   = 1'b0;
  logic hs_b_q   = 1'b0;

  handshake_peer_if #(.WIDTH(8)) bus_a ();
  handshake_peer_if #(.WIDTH(8)) bus_b ();

  handshake_peer #(
    .WIDTH(8), .DEBOUNCE_CYCLES(16), .MIN_HOLD(4), .GAP_CYCLES(4)
  ) dut_a (
    .Clock(clk), .nReset(rst_n), .bus(bus_a)
  );

  handshake_peer #(
    .WIDTH(8), .DEBOUNCE_CYCLES(1), .MIN_HOLD(8), .GAP_CYCLES(4)
  ) dut_b (
    .Clock(clk), .nReset(rst_n), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    hs_a_q <= bus_a.Handshake;
    hs_b_q <= bus_b.Handshake;
    if (bus_a.Handshake === 1'b1 && hs_a_q !== 1'b1) rises_a <= rises_a + 1;
    if (bus_b.Handshake === 1'b1 && hs_b_q !== 1'b1) rises_b <= rises_b + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic txn_a();
    bus_a.Button = 1'b1;
    step(25);
    bus_a.Button = 1'b0;
    step(30);
  endtask

  task automatic txn_b();
    bus_b.Button = 1'b1;
    step(2);
    bus_b.Button = 1'b0;
    step(16);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus_a.Button     = 1'b0;
    bus_a.SwitchesIn = 8'h00;
    bus_a.ResultIn   = 8'h00;
    bus_b.Button     = 1'b0;
    bus_b.SwitchesIn = 8'h00;
    bus_b.ResultIn   = 8'h00;
    step(2);
    chk("rst_hs",    32'(bus_a.Handshake),  32'h0);
    chk("rst_sw",    32'(bus_a.SW),         32'h0);
    chk("rst_led",   32'(bus_a.LedOut),     32'h0);
    chk("rst_count", 32'(bus_a.PressCount), 32'h0);
    chk("rst_busy",  32'(bus_a.Busy),       32'h0);
    rst_n = 1'b1;
    step(1);

    // Clean press: rise 19 cycles after the button edge, fall 19 after release.
    bus_a.SwitchesIn = 8'hA5;
    bus_a.ResultIn   = 8'h3C;
    bus_a.Button     = 1'b1;
    step(18);
    chk("clean_hs_before_rise", 32'(bus_a.Handshake), 32'h0);
    chk("clean_busy_before",    32'(bus_a.Busy),      32'h0);
    step(1);
    chk("clean_hs_rise", 32'(bus_a.Handshake), 32'h1);
    chk("clean_sw",      32'(bus_a.SW),        32'hA5);
    chk("clean_busy",    32'(bus_a.Busy),      32'h1);
    step(21);
    bus_a.Button     = 1'b0;
    bus_a.SwitchesIn = 8'h5A;
    step(18);
    chk("clean_hs_held",     32'(bus_a.Handshake),  32'h1);
    chk("clean_led_pending", 32'(bus_a.LedOut),     32'h0);
    chk("clean_cnt_pending", 32'(bus_a.PressCount), 32'h0);
    step(1);
    chk("clean_hs_fall", 32'(bus_a.Handshake),  32'h0);
    chk("clean_led",     32'(bus_a.LedOut),     32'h3C);
    chk("clean_count",   32'(bus_a.PressCount), 32'h1);
    chk("clean_gap_busy", 32'(bus_a.Busy),      32'h1);
    chk("clean_sw_stable", 32'(bus_a.SW),       32'hA5);
    step(3);
    chk("clean_gap_busy_last", 32'(bus_a.Busy), 32'h1);
    step(1);
    chk("clean_idle_busy", 32'(bus_a.Busy), 32'h0);

    // Glitch rejection: 10-cycle pulses never reach the debounced level.
    for (int k = 0; k < 5; k++) begin
      bus_a.Button = 1'b1;
      step(10);
      bus_a.Button = 1'b0;
      step(3);
    end
    step(30);
    chk("glitch_rises", 32'(rises_a),          32'd1);
    chk("glitch_count", 32'(bus_a.PressCount), 32'h1);
    chk("glitch_hs",    32'(bus_a.Handshake),  32'h0);

    // Minimum hold with a 2-cycle pulse, then a press landing in GAP cycle 2.
    bus_b.SwitchesIn = 8'h11;
    bus_b.ResultIn   = 8'h22;
    bus_b.Button     = 1'b1;
    step(2);
    bus_b.Button = 1'b0;
    step(1);
    chk("hold_hs_before", 32'(bus_b.Handshake), 32'h0);
    step(1);
    chk("hold_hs_rise", 32'(bus_b.Handshake), 32'h1);
    chk("hold_sw",      32'(bus_b.SW),        32'h11);
    step(6);
    chk("hold_hs_mid", 32'(bus_b.Handshake), 32'h1);
    bus_b.SwitchesIn = 8'h77;
    bus_b.Button     = 1'b1;
    step(1);
    chk("hold_hs_last", 32'(bus_b.Handshake), 32'h1);
    step(1);
    chk("hold_hs_fall", 32'(bus_b.Handshake),  32'h0);
    chk("hold_led",     32'(bus_b.LedOut),     32'h22);
    chk("hold_count",   32'(bus_b.PressCount), 32'h1);
    step(2);
    bus_b.Button = 1'b0;
    step(20);
    chk("gap_press_rises", 32'(rises_b),          32'd1);
    chk("gap_press_hs",    32'(bus_b.Handshake),  32'h0);
    chk("gap_press_sw",    32'(bus_b.SW),         32'h11);
    chk("gap_press_count", 32'(bus_b.PressCount), 32'h1);
    chk("gap_press_busy",  32'(bus_b.Busy),       32'h0);

    // Counter wrap on the fast instance.
    for (int i = 0; i < 253; i++) begin
      bus_b.ResultIn = 8'(i);
      txn_b();
    end
    chk("wrap_254", 32'(bus_b.PressCount), 32'd254);
    bus_b.ResultIn = 8'hC3;
    txn_b();
    chk("wrap_255", 32'(bus_b.PressCount), 32'd255);
    bus_b.ResultIn = 8'h96;
    txn_b();
    chk("wrap_0",   32'(bus_b.PressCount), 32'd0);
    chk("wrap_led", 32'(bus_b.LedOut),     32'h96);

    // Asynchronous reset in the middle of HIGH.
    txn_a();
    txn_a();
    chk("pre_rst_count", 32'(bus_a.PressCount), 32'h3);
    bus_a.Button = 1'b1;
    step(22);
    chk("pre_rst_hs", 32'(bus_a.Handshake), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_hs",    32'(bus_a.Handshake),  32'h0);
    chk("arst_sw",    32'(bus_a.SW),         32'h0);
    chk("arst_led",   32'(bus_a.LedOut),     32'h0);
    chk("arst_count", 32'(bus_a.PressCount), 32'h0);
    chk("arst_busy",  32'(bus_a.Busy),       32'h0);
    bus_a.Button = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);
    chk("post_rst_busy",    32'(bus_a.Busy),       32'h0);
    chk("post_rst_hs",      32'(bus_a.Handshake),  32'h0);
    chk("post_rst_b_count", 32'(bus_b.PressCount), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
